// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges main-pipeline writebacks with buffered
// long-latency results onto a single register-file write port, and keeps
// a pending-register scoreboard for hazard detection at decode.
module writeback_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_wrd,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  src_a,
    input  logic [4:0]  src_b,
    output logic        hazard,
    output logic        wb_wrd,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
);

    // Storage is exactly two entries; the one-bit pointers below rely on that.
    localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

    logic [4:0]  fifo_addr_r [0:1];
    logic [31:0] fifo_data_r [0:1];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  count_r;
    logic [31:0] pending_r;

    logic        push_s;
    logic        pop_s;
    logic [4:0]  head_addr_s;
    logic [31:0] head_data_s;
    logic [1:0]  count_next_s;
    logic [31:0] set_mask_s;
    logic [31:0] clr_mask_s;
    logic [31:0] pending_next_s;

    // Ready comes only from the registered count, so a full FIFO never
    // accepts even when it is being popped in the same cycle.
    assign lu_ready = (count_r < DEPTH_C);

    // Register 0 is never pending, so it needs no special case here.
    assign hazard = pending_r[src_a] | pending_r[src_b] |
                    (issue_valid & pending_r[issue_addr]);

    // Handshake, FIFO head, occupancy and scoreboard next-state.
    always_comb begin
        push_s       = lu_valid && lu_ready;
        pop_s        = (!pipe_wrd) && (count_r != 2'd0);
        head_addr_s  = fifo_addr_r[rd_ptr_r];
        head_data_s  = fifo_data_r[rd_ptr_r];
        count_next_s = count_r;
        set_mask_s   = 32'd0;
        clr_mask_s   = 32'd0;

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase

        if (issue_valid && (issue_addr != 5'd0)) begin
            set_mask_s[issue_addr] = 1'b1;
        end else begin
            set_mask_s = 32'd0;
        end

        if (pop_s && (head_addr_s != 5'd0)) begin
            clr_mask_s[head_addr_s] = 1'b1;
        end else begin
            clr_mask_s = 32'd0;
        end

        // Clear first, then set, so a same-cycle re-issue keeps the bit.
        pending_next_s = ((pending_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_addr_r[i] <= 5'd0;
                fifo_data_r[i] <= 32'd0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_addr_r[wr_ptr_r] <= lu_addr;
                fifo_data_r[wr_ptr_r] <= lu_data;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_next_s;
        end
    end

    // Register-file write port: pipeline first, then FIFO head, else idle.
    // Writes to register 0 are consumed but never asserted on the port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_wrd  <= 1'b0;
            wb_addr <= 5'd0;
            wb_data <= 32'd0;
        end else if (pipe_wrd) begin
            wb_wrd  <= (pipe_addr != 5'd0);
            wb_addr <= pipe_addr;
            wb_data <= pipe_data;
        end else if (pop_s) begin
            wb_wrd  <= (head_addr_s != 5'd0);
            wb_addr <= head_addr_s;
            wb_data <= head_data_s;
        end else begin
            wb_wrd  <= 1'b0;
        end
    end

    // Pending-register scoreboard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= pending_next_s;
        end
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001: Parameter FIFO_DEPTH, default 2, number of buffered long-latency results (fixed at 2 for this release).
REQ-002: clk  input  1  single clock; all state updates on posedge.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: pipe_wrd  input  1  main-pipeline writeback request this cycle.
REQ-005: pipe_addr  input  5  main-pipeline destination register.
REQ-006: pipe_data  input  32  main-pipeline writeback data.
REQ-007: lu_valid  input  1  long-latency unit (mul/div/load-miss) result valid.
REQ-008: lu_addr  input  5  long-latency result destination.
REQ-009: lu_data  input  32  long-latency result data.
REQ-010: lu_ready  output  1  arbiter can accept a long-latency result.
REQ-011: issue_valid  input  1  long-latency op issued this cycle.
REQ-012: issue_addr  input  5  destination of the issued op.
REQ-013: src_a, src_b  input  5 each  decode-stage source registers to check.
REQ-014: hazard  output  1  combinational: a checked register is pending.
REQ-015: wb_wrd, wb_addr, wb_data  output  1/5/32  registered write port to the register file (wrd/addr_d/d).

Function
REQ-016: Result transfer on lu_valid && lu_ready at posedge; data pushed into FIFO; lu_valid with lu_ready=0 holds, nothing lost.
REQ-017: lu_ready SHALL equal (FIFO count < 2), from registered count; no push-when-full even with simultaneous pop.
REQ-018: Pipeline port SHALL have strict priority; no stall, no ready signal.
REQ-019: Each posedge: if pipe_wrd, next wb_* = {1, pipe_addr, pipe_data}; else if FIFO non-empty, next wb_* = FIFO head and head popped; else wb_wrd=0, wb_addr/wb_data hold.
REQ-020: Latency: pipeline request to wb_wrd = 1 cycle; long-latency result into empty FIFO with no pipeline traffic = 2 cycles (push, then pop).
REQ-021: FIFO SHALL be strict in-order; simultaneous push and pop in one cycle allowed when count is 1 (count stays 1).
REQ-022: Any write with address 0 SHALL produce wb_wrd=0 (FIFO entry still popped, pipeline request consumed).
REQ-023: Scoreboard: 32-bit pending vector; bit 0 permanently 0.
REQ-024: issue_valid && issue_addr!=0 SHALL set pending[issue_addr] at posedge.
REQ-025: FIFO pop with head address r!=0 SHALL clear pending[r] at the same posedge.
REQ-026: Simultaneous set and clear of the same bit: set wins (bit stays 1).
REQ-027: hazard = pending[src_a] | pending[src_b] | (issue_valid & pending[issue_addr]); upstream SHALL not issue while hazard; issuing anyway leaves the bit set (idempotent).
REQ-028: Pipeline write to a pending register SHALL NOT clear pending.

Reset
REQ-029: reset asserted SHALL immediately force wb_wrd=0, wb_addr=0, wb_data=0, FIFO count=0, all pending=0, lu_ready=1 after count clears, independent of clk.
REQ-030: Reset mid-operation SHALL discard buffered results without emitting writes; first write possible on first posedge after deassertion.

Verification
REQ-031: pipe_wrd=1, addr=5, data=0xDEADBEEF, FIFO empty -> next cycle wb_wrd=1, wb_addr=5, wb_data=0xDEADBEEF.
REQ-032: issue addr 7; 3 cycles later lu result addr 7 data 0x12 with no pipe traffic -> hazard=1 for src_a=7 until wb_wrd=1/addr 7/0x12, then pending[7]=0, hazard=0.
REQ-033: lu results A(3,0x1), B(4,0x2) pushed while pipe_wrd=1 for 4 cycles -> lu_ready=0 after 2 pushes; pipe writes emitted first, then A, then B in order.
REQ-034: lu result addr 0 or pipe_wrd with addr 0 -> wb_wrd stays 0; FIFO drains.
REQ-035: issue addr 9 in same cycle as FIFO pop of addr 9 -> pending[9]=1 afterwards.
REQ-036: reset pulsed with 2 FIFO entries and pending[3,4] set -> outputs 0 asynchronously, lu_ready=1, hazard=0, no writes emitted after release.
